// File: rtl/inst_queue_pkg.sv
// Shared fetch/decode constants for the instruction prefetch queue.
package inst_queue_pkg;

  localparam int unsigned IQ_ADDR_W   = 6;
  localparam int unsigned IQ_INST_W   = 32;
  localparam int unsigned QUEUE_DEPTH = 4;

  // sll $0,$0,0 encodes as all zeroes, so an idle output is a NOP to decode.
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

endpackage

// File: rtl/iq_storage.sv
// Entry storage for the instruction queue: one synchronous write port and
// one asynchronous read port.
module iq_storage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 38
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction prefetch queue between fetch and decode. Buffers {pc, inst}
// pairs in order, show-ahead head, synchronous flush on redirect.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = QUEUE_DEPTH,
  parameter int unsigned ADDR_W = IQ_ADDR_W,
  parameter int unsigned INST_W = IQ_INST_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_inst,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = ADDR_W + INST_W;

  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] rd_entry;

  // in_ready looks only at registered count so it never depends on out_ready.
  assign in_ready  = !rst && !flush && (count_q != CNT_W'(DEPTH));
  assign out_valid = !rst && (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  iq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({in_pc, in_inst}),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign out_pc   = out_valid ? rd_entry[ENTRY_W-1:INST_W] : '0;
  assign out_inst = out_valid ? rd_entry[INST_W-1:0] : INST_W'(INST_NOP);

  // Fetch must hold a refused pair steady until it is taken or withdrawn.
  assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready) |=> (!in_valid || ($stable(in_pc) && $stable(in_inst))));

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue against a queue-based reference model.
module tb_inst_queue;

  localparam int DEPTH = 4;

  typedef logic [37:0] entry_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [5:0]  in_pc;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic [5:0]  out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic [2:0]  count;

  int checks;
  int errors;

  entry_t model[$];

  inst_queue dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] exp_cnt();
    return 3'(model.size());
  endfunction

  function automatic logic exp_valid();
    return model.size() != 0;
  endfunction

  function automatic logic [5:0] exp_pc();
    entry_t e;
    if (model.size() == 0) return 6'h0;
    e = model[0];
    return e[37:32];
  endfunction

  function automatic logic [31:0] exp_inst();
    entry_t e;
    if (model.size() == 0) return 32'h0;
    e = model[0];
    return e[31:0];
  endfunction

  // Advance one rising edge with the current inputs and update the model.
  task automatic tick();
    bit do_push;
    bit do_pop;
    do_push = in_valid && !flush && (model.size() < DEPTH);
    do_pop  = out_ready && !flush && (model.size() != 0);
    @(posedge clk);
    if (flush) begin
      model.delete();
    end else begin
      if (do_pop) void'(model.pop_front());
      if (do_push) model.push_back({in_pc, in_inst});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 1; in_pc = 6'h0; in_inst = 32'h3401_0000; out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0) begin errors++;
        $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++;
        $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_inst !== 32'h0) begin errors++;
        $display("FAIL reset_out_inst: got %h expected 0", out_inst); end
      checks++; if (out_pc !== 6'h0) begin errors++;
        $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
    end
    model.delete();
    rst = 0; in_valid = 0; #1;
    checks++; if (count !== 3'd0) begin errors++;
      $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_fill_drain();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_pc = 6'(i); in_inst = 32'(32'h3401_0000 + i); #1;
      checks++; if (in_ready !== 1'b1) begin errors++;
        $display("FAIL fill_in_ready: got %b expected 1", in_ready); end
      if (i == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++;
          $display("FAIL no_bypass: got out_valid %b expected 0", out_valid); end
      end
      tick();
      checks++; if (count !== exp_cnt()) begin errors++;
        $display("FAIL fill_count: got %0d expected %0d", count, exp_cnt()); end
      checks++; if (out_pc !== 6'h0) begin errors++;
        $display("FAIL fill_head_pc: got %h expected 0", out_pc); end
    end
    in_valid = 0; #1;
    checks++; if (count !== 3'd4) begin errors++;
      $display("FAIL full_count: got %0d expected 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++;
        $display("FAIL drain_valid: got %b expected 1", out_valid); end
      checks++; if (out_pc !== 6'(i)) begin errors++;
        $display("FAIL drain_pc: got %h expected %h", out_pc, 6'(i)); end
      checks++; if (out_inst !== 32'(32'h3401_0000 + i)) begin errors++;
        $display("FAIL drain_inst: got %h expected %h", out_inst, 32'(32'h3401_0000 + i)); end
      tick();
    end
    checks++; if (count !== 3'd0) begin errors++;
      $display("FAIL drain_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0 || out_inst !== 32'h0) begin errors++;
      $display("FAIL drain_empty_nop: got valid %b inst %h expected 0/0", out_valid, out_inst); end
  endtask

  task automatic test_streaming();
    logic [5:0] pc;
    logic [5:0] last;
    bit have_last;
    pc = 6'h3c; last = 6'h0; have_last = 0;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      in_pc = pc; in_inst = $urandom; #1;
      if (out_valid === 1'b1) begin
        if (have_last) begin
          checks++; if (out_pc !== 6'(last + 1)) begin errors++;
            $display("FAIL stream_contig: got %h expected %h", out_pc, 6'(last + 1)); end
        end
        last = out_pc; have_last = 1;
      end
      checks++; if (out_pc !== exp_pc() || out_inst !== exp_inst()) begin errors++;
        $display("FAIL stream_head: got %h/%h expected %h/%h", out_pc, out_inst, exp_pc(),
                 exp_inst()); end
      tick();
      pc = pc + 6'd1;
      checks++; if (count !== 3'd1) begin errors++;
        $display("FAIL stream_count: got %0d expected 1", count); end
    end
    in_valid = 0;
  endtask

  task automatic test_full_pop();
    in_valid = 0; out_ready = 1;
    while (model.size() != 0) tick();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_pc = 6'(i + 8); in_inst = $urandom; tick();
    end
    in_valid = 1; in_pc = 6'h20; in_inst = 32'hdead_beef; out_ready = 1; #1;
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++;
      $display("FAIL fullpop_pre: got count %0d in_ready %b expected 4/0", count, in_ready); end
    tick();
    checks++; if (count !== 3'd3) begin errors++;
      $display("FAIL fullpop_refused: got %0d expected 3", count); end
    checks++; if (out_pc !== 6'h9) begin errors++;
      $display("FAIL fullpop_head: got %h expected 09", out_pc); end
    out_ready = 0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL fullpop_retry_ready: got %b expected 1", in_ready); end
    tick();
    checks++; if (count !== 3'd4) begin errors++;
      $display("FAIL fullpop_retry_count: got %0d expected 4", count); end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_pc !== exp_pc() || out_inst !== exp_inst()) begin errors++;
        $display("FAIL fullpop_drain: got %h/%h expected %h/%h", out_pc, out_inst, exp_pc(),
                 exp_inst()); end
      if (i == 3) begin
        checks++; if (out_pc !== 6'h20 || out_inst !== 32'hdead_beef) begin errors++;
          $display("FAIL fullpop_tail: got %h/%h expected 20/deadbeef", out_pc, out_inst); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_pc = 6'(6'h30 + i); in_inst = $urandom; tick();
    end
    checks++; if (count !== 3'd3) begin errors++;
      $display("FAIL flush_pre_count: got %0d expected 3", count); end
    flush = 1; in_valid = 1; in_pc = 6'h2a; in_inst = $urandom; out_ready = 1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    tick();
    flush = 0; in_valid = 0; #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_inst !== 32'h0) begin errors++;
      $display("FAIL flush_after: got count %0d valid %b inst %h expected 0/0/0", count,
               out_valid, out_inst); end
    tick();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL flush_not_stored: got count %0d valid %b expected 0/0", count, out_valid); end
  endtask

  task automatic test_random();
    logic [5:0] pc;
    bit pend;
    bit redirect;
    bit acc;
    logic exp_rdy;
    pc = 6'h0; pend = 0; redirect = 0;
    for (int i = 0; i < 800; i++) begin
      if (redirect) begin
        in_valid = 0; pc = 6'($urandom); pend = 0; redirect = 0;
      end else if (!pend) begin
        in_valid = ($urandom_range(0, 3) != 0); in_pc = pc; in_inst = $urandom;
      end
      flush = ($urandom_range(0, 24) == 0);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = !flush && (model.size() < DEPTH);
      checks++; if (in_ready !== exp_rdy) begin errors++;
        $display("FAIL rand_in_ready: got %b expected %b", in_ready, exp_rdy); end
      checks++; if (out_valid !== exp_valid()) begin errors++;
        $display("FAIL rand_out_valid: got %b expected %b", out_valid, exp_valid()); end
      checks++; if (out_pc !== exp_pc() || out_inst !== exp_inst()) begin errors++;
        $display("FAIL rand_head: got %h/%h expected %h/%h", out_pc, out_inst, exp_pc(),
                 exp_inst()); end
      checks++; if (count !== exp_cnt()) begin errors++;
        $display("FAIL rand_count: got %0d expected %0d", count, exp_cnt()); end
      acc = in_valid && exp_rdy;
      tick();
      if (flush) redirect = 1;
      else if (acc) begin pc = pc + 6'd1; pend = 0; end
      else pend = in_valid;
    end
    flush = 0; in_valid = 0;
  endtask

  task automatic test_reset_mid();
    out_ready = 0; flush = 0;
    while (model.size() < 2) begin
      in_valid = 1; in_pc = 6'(model.size() + 5); in_inst = $urandom; tick();
    end
    in_valid = 0; rst = 1; #1;
    checks++; if (out_valid !== 1'b0 || out_pc !== 6'h0 || in_ready !== 1'b0) begin errors++;
      $display("FAIL midrst_outputs: got valid %b pc %h ready %b expected 0/0/0", out_valid,
               out_pc, in_ready); end
    @(posedge clk); #1;
    model.delete();
    rst = 0; #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL midrst_after: got count %0d valid %b expected 0/0", count, out_valid); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1; flush = 0; in_valid = 0; in_pc = 6'h0; in_inst = 32'h0; out_ready = 0;
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_pop();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
